// File: rtl/dmem_responder.sv
// Word-addressed data RAM behind valid/ready request and response channels, answering
// each request a fixed LATENCY after accept. Define DMEM_ERR_CHECK_EN to flag misaligned/out-of-range accesses.
module dmem_responder #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [3:0]        req_be,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err
);
  localparam int NUM_LANES = DATA_W / 8;
  localparam int IDX_W     = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int WIDX_W    = ADDR_W - 2;
  localparam logic [WIDX_W-1:0] DEPTH_L  = WIDX_W'(DEPTH_WORDS);
  localparam logic [3:0]        CNT_INIT = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  typedef struct packed {
    logic                 we;
    logic [ADDR_W-1:0]    addr;
    logic [DATA_W-1:0]    wdata;
    logic [NUM_LANES-1:0] be;
  } req_t;

  state_t            state, state_nxt;
  logic [3:0]        cnt, cnt_nxt;
  logic              accept, commit, acc_err;
  req_t              req_in, req_q, req_eff;
  logic [WIDX_W-1:0] widx_full, widx_mod;
  logic [IDX_W-1:0]  widx;
  logic [DATA_W-1:0] mem [DEPTH_WORDS];

  assign req_in = '{we: req_we, addr: req_addr, wdata: req_wdata, be: req_be};
  assign accept = req_valid && req_ready;

  // With LATENCY=0 the commit edge is the accept edge, so the live request is used in IDLE.
  assign req_eff   = (state == IDLE) ? req_in : req_q;
  assign widx_full = req_eff.addr[ADDR_W-1:2];
  assign widx_mod  = widx_full % DEPTH_L;
  assign widx      = widx_mod[IDX_W-1:0];

`ifdef DMEM_ERR_CHECK_EN
  assign acc_err = (req_eff.addr[1:0] != 2'b00) || (widx_full >= DEPTH_L);
`else
  assign acc_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    commit    = 1'b0;
    unique case (state)
      IDLE: if (accept) begin
        if (LATENCY == 0) begin
          state_nxt = RESP;
          commit    = 1'b1;
        end else begin
          state_nxt = WAIT;
          cnt_nxt   = CNT_INIT;
        end
      end
      WAIT: if (cnt == 4'd0) begin
        state_nxt = RESP;
        commit    = 1'b1;
      end else begin
        cnt_nxt = cnt - 4'd1;
      end
      RESP: if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // req_ready is gated by reset so it reads 0 for the whole reset pulse.
  always_comb begin
    req_ready = (state == IDLE) && reset;
    rsp_valid = (state == RESP);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)      req_q <= '0;
    else if (accept) req_q <= req_in;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else if (commit) begin
      rsp_err   <= acc_err;
      rsp_rdata <= (req_eff.we || acc_err) ? '0 : mem[widx];
    end
  end

  // Array has no reset: contents survive reset and can be preloaded hierarchically.
  always_ff @(posedge clk) begin
    if (commit && req_eff.we && !acc_err) begin
      for (int i = 0; i < NUM_LANES; i++)
        if (req_eff.be[i]) mem[widx][8*i +: 8] <= req_eff.wdata[8*i +: 8];
    end
  end
endmodule
